// File: rtl/demux_lane_scheduler_pkg.sv
// Shared types, default sizes and helpers for the bit-demux lane scheduler.
package demux_sched_pkg;

    localparam int DEF_NB_LANES       = 4;
    localparam int DEF_SEL_W          = 2;
    localparam int DEF_SYMS_PER_FRAME = 8;
    localparam int DEF_CNT_W          = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } schedState_t;

    // Index of the lowest set bit; 0 when the mask is empty.
    function automatic logic [DEF_SEL_W-1:0] lowest_set(input logic [DEF_NB_LANES-1:0] mask);
        logic [DEF_SEL_W-1:0] res;
        res = '0;
        for (int i = DEF_NB_LANES - 1; i >= 0; i--) begin
            if (mask[i]) begin
                res = DEF_SEL_W'(i);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/demux_lane_scheduler_lane_next_finder.sv
// Combinational search for the next enabled lane above the current one.
module lane_next_finder #(
    parameter int NB_LANES = 4,
    parameter int SEL_W    = 2
) (
    input  logic [NB_LANES-1:0] inMask,
    input  logic [SEL_W-1:0]    inLane,
    output logic [SEL_W-1:0]    outNextLane,
    output logic                outIsLast
);

    // Scan downward so the final hit is the closest set lane above inLane.
    always_comb begin
        outNextLane = inLane;
        outIsLast   = 1'b1;
        for (int i = NB_LANES - 1; i >= 0; i--) begin
            if (inMask[i] && (i > int'(inLane))) begin
                outNextLane = SEL_W'(i);
                outIsLast   = 1'b0;
            end
        end
    end

endmodule

// File: rtl/demux_lane_scheduler.sv
// Lane scheduler for the 1:4 bit demux: steers serial bits round-robin over
// the enabled lanes, assembles symbols and counts them per frame.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for inEnable with a non-zero lane mask
// COLLECT | accepting bits, one per enabled lane, ascending
// HOLD    | symbol complete, presented until inSymbolReady
module demux_lane_scheduler
    import demux_sched_pkg::*;
#(
    parameter int NB_LANES       = DEF_NB_LANES,
    parameter int SEL_W          = DEF_SEL_W,
    parameter int SYMS_PER_FRAME = DEF_SYMS_PER_FRAME,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic                inClock,
    input  logic                inReset,
    input  logic                inEnable,
    input  logic [NB_LANES-1:0] inLaneMask,
    input  logic                inBitValid,
    input  logic                inBit,
    output logic                outBitReady,
    output logic [SEL_W-1:0]    outSel,
    output logic [NB_LANES-1:0] outLaneStrobe,
    output logic [NB_LANES-1:0] outSymbol,
    output logic                outSymbolValid,
    input  logic                inSymbolReady,
    output logic                outLast,
    output logic                outBusy,
    output logic                outCfgErr
);

    schedState_t         state;
    logic [NB_LANES-1:0] maskLatched;
    logic [CNT_W-1:0]    symCount;
    logic [SEL_W-1:0]    nextLane;
    logic                laneIsLast;
    logic                bitAccept;
    logic                isLastSym;

    // outSel doubles as the current-lane register.
    lane_next_finder #(
        .NB_LANES (NB_LANES),
        .SEL_W    (SEL_W)
    ) uNextFinder (
        .inMask      (maskLatched),
        .inLane      (outSel),
        .outNextLane (nextLane),
        .outIsLast   (laneIsLast)
    );

    assign bitAccept     = inBitValid & outBitReady;
    assign outLaneStrobe = bitAccept ? (NB_LANES'(1) << outSel) : '0;
    assign isLastSym     = (symCount == CNT_W'(SYMS_PER_FRAME - 1));

    // Scheduler FSM; every output except the strobe is registered here.
    always_ff @(posedge inClock) begin
        if (inReset) begin
            state          <= IDLE;
            maskLatched    <= '0;
            symCount       <= '0;
            outSel         <= '0;
            outSymbol      <= '0;
            outBitReady    <= 1'b0;
            outSymbolValid <= 1'b0;
            outLast        <= 1'b0;
            outBusy        <= 1'b0;
            outCfgErr      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (inEnable && (inLaneMask != '0)) begin
                        maskLatched <= inLaneMask;
                        outSel      <= lowest_set(inLaneMask);
                        outSymbol   <= '0;
                        symCount    <= '0;
                        outBitReady <= 1'b1;
                        outBusy     <= 1'b1;
                        outCfgErr   <= 1'b0;
                        state       <= COLLECT;
                    end else begin
                        // Error tracks an enable request with an empty mask.
                        outCfgErr <= inEnable;
                    end
                end
                COLLECT: begin
                    if (!inEnable) begin
                        // Abort drops the partial symbol; nothing is emitted.
                        symCount    <= '0;
                        outSymbol   <= '0;
                        outBitReady <= 1'b0;
                        outBusy     <= 1'b0;
                        state       <= IDLE;
                    end else if (bitAccept) begin
                        outSymbol[outSel] <= inBit;
                        if (laneIsLast) begin
                            outBitReady    <= 1'b0;
                            outSymbolValid <= 1'b1;
                            outLast        <= isLastSym;
                            state          <= HOLD;
                        end else begin
                            outSel <= nextLane;
                        end
                    end
                end
                HOLD: begin
                    if (inSymbolReady) begin
                        outSymbolValid <= 1'b0;
                        outLast        <= 1'b0;
                        if (outLast) begin
                            symCount <= '0;
                            outBusy  <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            symCount    <= symCount + CNT_W'(1);
                            outSymbol   <= '0;
                            outSel      <= lowest_set(maskLatched);
                            outBitReady <= 1'b1;
                            state       <= COLLECT;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/demux_lane_scheduler.md
Name: demux_lane_scheduler

Overview:
- Sequences the 1:4 bit demultiplexer in the Zigbee TX/RX datapath.
- Accepts a serial bit stream over a valid/ready handshake and steers each bit to the next enabled lane (round-robin, ascending, wrap).
- Drives the demux select and a per-lane strobe, and assembles each lane group into a 4-bit symbol delivered over a second valid/ready handshake.
- Counts symbols per frame and flags the last one.

Parameters:
- NB_LANES, 4, number of demux lanes (symbol width).
- SEL_W, 2, select width, equal to log2(NB_LANES).
- SYMS_PER_FRAME, 8, symbols per frame; range 1..255.
- CNT_W, 8, symbol counter width.

Ports:
- inClock  input  1  single clock; all logic on rising edge.
- inReset  input  1  synchronous, active-high reset.
- inEnable  input  1  start/continue frames; low aborts a partial symbol.
- inLaneMask  input  NB_LANES  enabled lanes; latched at frame start.
- inBitValid  input  1  serial bit valid.
- inBit  input  1  serial data bit.
- outBitReady  output  1  scheduler can accept a bit.
- outSel  output  SEL_W  demux select = current lane.
- outLaneStrobe  output  NB_LANES  one-hot, high in the cycle a bit is accepted into that lane.
- outSymbol  output  NB_LANES  assembled symbol; disabled lanes read 0.
- outSymbolValid  output  1  symbol available.
- inSymbolReady  input  1  downstream accepts symbol.
- outLast  output  1  qualifies outSymbolValid; last symbol of frame.
- outBusy  output  1  state != IDLE.
- outCfgErr  output  1  enable requested with all-zero mask.

Behaviour:
- Reset (inReset=1 at a clock edge):
  - state=IDLE; every output 0.
  - lane=0, symbol counter=0, latched mask=0, symbol register=0.
- States: IDLE, COLLECT, HOLD.
- IDLE:
  - outBitReady=0.
  - inEnable=1 and inLaneMask!=0: latch mask, lane = lowest set mask bit, clear symbol register, counter=0, go COLLECT next cycle.
  - inEnable=1 and inLaneMask==0: stay IDLE; outCfgErr=1 (registered, one cycle later, held while the condition holds).
- COLLECT:
  - outBitReady=1; outSel=lane.
  - Accept = inBitValid & outBitReady.
  - On accept:
    - outSymbol[lane] <= inBit.
    - outLaneStrobe[lane]=1, combinational with accept.
    - If lane is the highest set mask bit: go HOLD.
    - Else: lane <= next set mask bit above lane.
  - inEnable=0 at any edge in COLLECT (with or without an accept): discard partial symbol, counter=0, go IDLE. No symbol is emitted.
- HOLD:
  - outSymbolValid=1; outBitReady=0; outSymbol stable.
  - outLast=1 iff counter==SYMS_PER_FRAME-1.
  - inEnable is ignored in HOLD.
  - On inSymbolReady=1:
    - If last: go IDLE, counter=0.
    - Else: counter++, symbol register cleared, lane = lowest set mask bit, go COLLECT.
- Latency:
  - outSymbolValid rises the cycle after the accepting edge of the final lane bit.
  - One bubble cycle (outBitReady=0) always separates symbols.
- Mask:
  - Sampled only in IDLE.
  - Changes mid-frame take effect at the next frame.
  - Single-lane mask: every accepted bit completes a symbol.
- Counter wraps only through frame end; it never exceeds SYMS_PER_FRAME-1.
- Sync reset asserted mid-frame or in HOLD: immediate return to reset values next edge; pending symbol dropped.
- outSel is held (not reset to 0) while in HOLD.

Decomposition:
- Package demux_sched_pkg:
  - state enum (IDLE, COLLECT, HOLD).
  - NB_LANES/SEL_W defaults.
  - function lowest_set(mask).
- One sub-module, lane_next_finder:
  - Combinational.
  - Given mask and current lane, returns next set lane above current, plus an is_last flag.

Test Plan:
- Mask 4'b1111, SYMS_PER_FRAME=2, bits 1,0,1,1 then 0,0,0,1, ready always high:
  - outSel sequence 0,1,2,3.
  - Symbols 4'b1101 then 4'b1000.
  - outLast only on the second symbol; then IDLE.
- Mask 4'b0101, bits 1,1:
  - outSel 0 then 2; strobes 0001, 0100.
  - Symbol 4'b0101, valid one cycle after the second accept.
- Backpressure: inSymbolReady low 5 cycles in HOLD:
  - outSymbolValid and outSymbol stable; outBitReady=0 throughout.
  - Release → COLLECT next cycle.
- inEnable dropped after 2 bits in COLLECT:
  - No outSymbolValid; IDLE next cycle; outBusy=0.
  - Next frame's symbol 0 starts at lane 0.
- inEnable=1 with inLaneMask=0:
  - outCfgErr=1 from the next cycle; outBusy=0.
  - Mask set to 4'b0010 → outCfgErr=0, COLLECT, outSel=1.
- inReset pulse while in HOLD with valid symbol:
  - Next cycle all outputs 0, state IDLE, counter 0.
